// File: rtl/key_matrix_scanner_pkg.sv
// Shared types and constants for the 8x8 key matrix scanner.
// Imported by the scanner top, its event interface and the bench.
package key_matrix_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 8;

    typedef enum logic [2:0] {
        SETTLE,
        SAMPLE,
        EVAL,
        EMIT,
        GUARD
    } scan_state_t;

    typedef logic [5:0] key_index_t;

endpackage

// File: rtl/key_matrix_scanner_if.sv
// Key event stream: one press/release per valid/ready handshake.
// The scanner drives the master side, the UI consumer the slave side.
interface key_matrix_scanner_if;
    import key_matrix_pkg::*;

    logic       event_valid;
    logic       event_ready;
    key_index_t event_key;
    logic       event_pressed;

    modport master (
        output event_valid,
        output event_key,
        output event_pressed,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_key,
        input  event_pressed,
        output event_ready
    );

endinterface

// File: rtl/key_matrix_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Resets to all-ones, the idle pulled-up level of the columns.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: row-at-a-time drive, per-key debounce,
// press/release events on a valid/ready stream that stalls the scan.
module key_matrix_scanner
    import key_matrix_pkg::*;
#(
    parameter int CLOCK_HZ          = 27_000_000,
    parameter int ROW_PERIOD_CYCLES = CLOCK_HZ / 1000,
    parameter int SETTLE_CYCLES     = CLOCK_HZ / 50000,
    parameter int DEBOUNCE_SCANS    = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    output logic [NUM_ROWS-1:0]            row,
    input  logic [NUM_COLS-1:0]            col,
    key_matrix_scanner_if.master           evt,
    output logic [NUM_ROWS*NUM_COLS-1:0]   key_state
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3");
    end
    if (ROW_PERIOD_CYCLES < 2 * SETTLE_CYCLES + 9) begin : g_bad_period
        $error("ROW_PERIOD_CYCLES must be at least 2*SETTLE_CYCLES+9");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be at least 1");
    end

    scan_state_t state_q, state_d;
    logic [2:0]  row_index, row_index_d;
    logic [2:0]  col_index;
    logic [31:0] period_cnt;
    logic [31:0] guard_cnt;
    logic [NUM_COLS-1:0] col_sync;
    logic [NUM_COLS-1:0] raw;
    logic [NUM_ROWS-1:0] row_d;
    logic [NUM_ROWS*NUM_COLS-1:0][CW-1:0] cnt;

    logic       ev_valid;
    key_index_t ev_key;
    logic       ev_pressed;

    key_index_t key;
    logic       differ;
    logic       hit;
    logic       handshake;
    logic       guard_done;

    sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (col),
        .q       (col_sync)
    );

    assign evt.event_valid   = ev_valid;
    assign evt.event_key     = ev_key;
    assign evt.event_pressed = ev_pressed;

    assign key       = {row_index, col_index};
    assign differ    = raw[col_index] != key_state[key];
    assign hit       = differ && (int'(cnt[key]) + 1 >= DEBOUNCE_SCANS);
    assign handshake = ev_valid && evt.event_ready;
    // Guard must both finish the nominal slot and be long enough
    // for the columns to recover before the next row is driven.
    assign guard_done = (period_cnt >= 32'(ROW_PERIOD_CYCLES - 1))
                     && (guard_cnt >= 32'(SETTLE_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= SETTLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        row_index_d = row_index;
        unique case (state_q)
            SETTLE: begin
                if (period_cnt >= 32'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
            end
            SAMPLE: state_d = EVAL;
            EVAL: begin
                if (hit)                    state_d = EMIT;
                else if (col_index == 3'd7) state_d = GUARD;
            end
            EMIT: begin
                if (handshake) state_d = (col_index == 3'd7) ? GUARD : EVAL;
            end
            GUARD: begin
                if (guard_done) begin
                    state_d     = SETTLE;
                    row_index_d = row_index + 3'd1;
                end
            end
            default: state_d = SETTLE;
        endcase
        row_d = (state_d == GUARD) ? '1 : ~(NUM_ROWS'(1) << row_index_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row        <= '1;
            row_index  <= '0;
            col_index  <= '0;
            period_cnt <= '0;
            guard_cnt  <= '0;
            raw        <= '0;
            cnt        <= '0;
            key_state  <= '0;
            ev_valid   <= 1'b0;
            ev_key     <= '0;
            ev_pressed <= 1'b0;
        end else begin
            row       <= row_d;
            row_index <= row_index_d;
            if (state_q == GUARD && state_d == SETTLE) period_cnt <= '0;
            else if (period_cnt != '1) period_cnt <= period_cnt + 32'd1;
            guard_cnt <= (state_q == GUARD) ? guard_cnt + 32'd1 : '0;
            unique case (state_q)
                SAMPLE: begin
                    raw       <= ~col_sync;
                    col_index <= '0;
                end
                EVAL: begin
                    if (!differ || hit) cnt[key] <= '0;
                    else                cnt[key] <= cnt[key] + 1'b1;
                    if (hit) begin
                        key_state[key] <= ~key_state[key];
                        ev_valid       <= 1'b1;
                        ev_key         <= key;
                        ev_pressed     <= ~key_state[key];
                    end else if (col_index != 3'd7) begin
                        col_index <= col_index + 3'd1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        ev_valid <= 1'b0;
                        if (col_index != 3'd7) col_index <= col_index + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
